// File: rtl/argmax_tree.sv
// Pipelined max/min-with-index reduction tree with ready/valid backpressure.
// One registered compare level per stage; the odd trailing slot of a level is passed through.
module argmax_tree #(
  parameter int DATA_WIDTH  = 32,
  parameter int CHANNELS    = 4,
  parameter int SIGNED      = 1,
  parameter int INDEX_WIDTH = $clog2(CHANNELS)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [DATA_WIDTH*CHANNELS-1:0] i_data,
  input  logic                           i_min,
  input  logic                           i_valid,
  output logic                           i_ready,
  output logic [DATA_WIDTH-1:0]          o_data,
  output logic [INDEX_WIDTH-1:0]         o_index,
  output logic                           o_valid,
  input  logic                           o_ready
);

  localparam int LEVELS = $clog2(CHANNELS);

  function automatic int slots_at(input int lvl);
    int n;
    n = CHANNELS;
    for (int i = 0; i < lvl; i++) n = (n + 1) / 2;
    return n;
  endfunction

  // Upper slot must strictly beat the lower one, so ties keep the lower channel index.
  function automatic logic upper_wins(input logic [DATA_WIDTH-1:0] lo,
                                      input logic [DATA_WIDTH-1:0] hi,
                                      input logic                  find_min);
    logic gt;
    logic lt;
    if (SIGNED != 0) begin
      gt = $signed(hi) > $signed(lo);
      lt = $signed(hi) < $signed(lo);
    end else begin
      gt = hi > lo;
      lt = hi < lo;
    end
    return find_min ? lt : gt;
  endfunction

  logic advance;

  assign advance = o_ready || !o_valid;
  assign i_ready = advance;

  // Level 0 is the raw input vector; levels 1..LEVELS are the registered stages.
  for (genvar l = 0; l <= LEVELS; l++) begin : gen_lvl
    localparam int N = slots_at(l);

    logic [DATA_WIDTH-1:0]  val [N];
    logic [INDEX_WIDTH-1:0] idx [N];
    logic                   mode;
    logic                   valid;

    if (l == 0) begin : g_src
      assign mode  = i_min;
      assign valid = i_valid;
      for (genvar k = 0; k < N; k++) begin : g_ch
        assign val[k] = i_data[DATA_WIDTH*k +: DATA_WIDTH];
        assign idx[k] = INDEX_WIDTH'(k);
      end
    end else begin : g_stage
      localparam int NP = slots_at(l - 1);

      logic [DATA_WIDTH-1:0]  nxt_val [N];
      logic [INDEX_WIDTH-1:0] nxt_idx [N];

      for (genvar j = 0; j < N; j++) begin : g_slot
        if (2*j + 1 < NP) begin : g_cmp
          logic take_hi;
          assign take_hi    = upper_wins(gen_lvl[l-1].val[2*j], gen_lvl[l-1].val[2*j+1],
                                         gen_lvl[l-1].mode);
          assign nxt_val[j] = take_hi ? gen_lvl[l-1].val[2*j+1] : gen_lvl[l-1].val[2*j];
          assign nxt_idx[j] = take_hi ? gen_lvl[l-1].idx[2*j+1] : gen_lvl[l-1].idx[2*j];
        end else begin : g_pass
          assign nxt_val[j] = gen_lvl[l-1].val[2*j];
          assign nxt_idx[j] = gen_lvl[l-1].idx[2*j];
        end
      end

      // Global stall: every stage holds together, bubbles are never collapsed.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          valid <= 1'b0;
          mode  <= 1'b0;
          for (int j = 0; j < N; j++) begin
            val[j] <= '0;
            idx[j] <= '0;
          end
        end else if (advance) begin
          valid <= gen_lvl[l-1].valid;
          mode  <= gen_lvl[l-1].mode;
          for (int j = 0; j < N; j++) begin
            val[j] <= nxt_val[j];
            idx[j] <= nxt_idx[j];
          end
        end
      end
    end
  end

  assign o_valid = gen_lvl[LEVELS].valid;
  assign o_data  = o_valid ? gen_lvl[LEVELS].val[0] : '0;
  assign o_index = o_valid ? gen_lvl[LEVELS].idx[0] : '0;

endmodule

// File: tb/tb_argmax_tree.sv
// Bench for argmax_tree: signed/unsigned 4-channel and signed 5-channel instances share stimulus
// and are compared every cycle against a result-pipeline model using a linear arg-max scan.
module tb_argmax_tree;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [63:0] data4;
  logic [39:0] data5;
  logic        i_valid, i_min, o_ready;

  logic [15:0] s4_data, u4_data;
  logic [7:0]  s5_data;
  logic [1:0]  s4_idx, u4_idx;
  logic [2:0]  s5_idx;
  logic        s4_ov, u4_ov, s5_ov;
  logic        s4_ir, u4_ir, s5_ir;

  argmax_tree #(.DATA_WIDTH(16), .CHANNELS(4), .SIGNED(1)) dut_s4 (
    .clk(clk), .rst(rst), .i_data(data4), .i_min(i_min), .i_valid(i_valid), .i_ready(s4_ir),
    .o_data(s4_data), .o_index(s4_idx), .o_valid(s4_ov), .o_ready(o_ready));

  argmax_tree #(.DATA_WIDTH(16), .CHANNELS(4), .SIGNED(0)) dut_u4 (
    .clk(clk), .rst(rst), .i_data(data4), .i_min(i_min), .i_valid(i_valid), .i_ready(u4_ir),
    .o_data(u4_data), .o_index(u4_idx), .o_valid(u4_ov), .o_ready(o_ready));

  argmax_tree #(.DATA_WIDTH(8), .CHANNELS(5), .SIGNED(1)) dut_s5 (
    .clk(clk), .rst(rst), .i_data(data5), .i_min(i_min), .i_valid(i_valid), .i_ready(s5_ir),
    .o_data(s5_data), .o_index(s5_idx), .o_valid(s5_ov), .o_ready(o_ready));

  typedef struct {
    logic [15:0] d;
    logic [31:0] i;
    int          c;
  } evt_t;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [15:0] v4 [4];
  logic [7:0]  v5 [5];

  // Model: per instance, one expected result per pipeline position.
  bit          mv [3][3];
  logic [15:0] md [3][3];
  int          mi [3][3];

  evt_t log_q0[$];
  evt_t log_q1[$];
  evt_t log_q2[$];

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic int levelsOf(input int d);
    return (d == 2) ? 3 : 2;
  endfunction

  function automatic int refArgmax(input longint vals[5], input int n, input bit is_min);
    int best;
    best = 0;
    for (int k = 1; k < n; k++)
      if (is_min ? (vals[k] < vals[best]) : (vals[k] > vals[best])) best = k;
    return best;
  endfunction

  task automatic modelClear();
    for (int d = 0; d < 3; d++)
      for (int s = 0; s < 3; s++) begin
        mv[d][s] = 1'b0;
        md[d][s] = '0;
        mi[d][s] = 0;
      end
  endtask

  task automatic modelEdge();
    longint vals[5];
    int     w, l;
    if (rst) begin
      modelClear();
      return;
    end
    for (int d = 0; d < 3; d++) begin
      l = levelsOf(d);
      if (o_ready || !mv[d][l-1]) begin
        for (int s = l - 1; s > 0; s--) begin
          mv[d][s] = mv[d][s-1];
          md[d][s] = md[d][s-1];
          mi[d][s] = mi[d][s-1];
        end
        for (int k = 0; k < 5; k++) begin
          if (d == 0)      vals[k] = (k < 4) ? longint'($signed(v4[k])) : 0;
          else if (d == 1) vals[k] = (k < 4) ? longint'(v4[k]) : 0;
          else             vals[k] = longint'($signed(v5[k]));
        end
        w = refArgmax(vals, (d == 2) ? 5 : 4, i_min);
        mv[d][0] = i_valid;
        md[d][0] = (d == 2) ? {8'h00, v5[w]} : v4[w];
        mi[d][0] = w;
      end
    end
  endtask

  task automatic checkCycle();
    logic        ov [3];
    logic        ir [3];
    logic [15:0] od [3];
    logic [31:0] oi [3];
    int          l;
    ov = '{s4_ov, u4_ov, s5_ov};
    ir = '{s4_ir, u4_ir, s5_ir};
    od = '{s4_data, u4_data, {8'h00, s5_data}};
    oi = '{{30'd0, s4_idx}, {30'd0, u4_idx}, {29'd0, s5_idx}};
    for (int d = 0; d < 3; d++) begin
      l = levelsOf(d);
      checkOutput($sformatf("d%0d_o_valid", d), {31'd0, ov[d]}, {31'd0, mv[d][l-1]});
      checkOutput($sformatf("d%0d_i_ready", d), {31'd0, ir[d]}, {31'd0, (o_ready || !mv[d][l-1])});
      checkOutput($sformatf("d%0d_o_data", d), {16'd0, od[d]}, mv[d][l-1] ? {16'd0, md[d][l-1]} : 32'd0);
      checkOutput($sformatf("d%0d_o_index", d), oi[d], mv[d][l-1] ? mi[d][l-1] : 0);
      if (ov[d] === 1'b1 && o_ready) begin
        if (d == 0)      log_q0.push_back('{od[d], oi[d], cyc});
        else if (d == 1) log_q1.push_back('{od[d], oi[d], cyc});
        else             log_q2.push_back('{od[d], oi[d], cyc});
      end
    end
  endtask

  // Drive one beat, check outputs mid-cycle, then advance the model across the edge.
  task automatic applyStimulus(input bit vld, input bit imin, input bit ordy, input bit rstv);
    rst     = rstv;
    i_valid = vld;
    i_min   = imin;
    o_ready = ordy;
    for (int k = 0; k < 4; k++) data4[16*k +: 16] = v4[k];
    for (int k = 0; k < 5; k++) data5[8*k +: 8] = v5[k];
    if (rstv) modelClear();
    @(negedge clk);
    checkCycle();
    @(posedge clk);
    cyc++;
    modelEdge();
    #1;
  endtask

  task automatic randomizeData();
    for (int k = 0; k < 4; k++) v4[k] = 16'($urandom);
    for (int k = 0; k < 5; k++) v5[k] = 8'($urandom);
    if ($urandom_range(0, 3) == 0) begin
      v4[2] = v4[1];
      v5[3] = v5[0];
    end
  endtask

  initial begin
    int a, r, n, stall, base0, base2;
    bit ordy, acc, imin;

    rst = 1'b1; i_valid = 1'b0; i_min = 1'b0; o_ready = 1'b1;
    data4 = '0; data5 = '0;
    modelClear();

    for (int c = 0; c < 4; c++) begin
      randomizeData();
      applyStimulus(1'b1, 1'($urandom), 1'b1, 1'b1);
    end
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);

    log_q0.delete(); log_q1.delete(); log_q2.delete();
    a = cyc + 1;
    v4 = '{16'd5, 16'hFFFD, 16'd12, 16'd7};
    v5 = '{8'd3, 8'd7, 8'd2, 8'd6, 8'd100};
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
    v4 = '{16'd9, 16'd9, 16'd9, 16'd9};
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
    v4 = '{16'd4, 16'd1, 16'd1, 16'd8};
    v5 = '{8'd3, 8'd7, 8'd2, 8'd6, 8'd1};
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
    for (int c = 0; c < 4; c++) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);

    checkOutput("dir_s4_count", log_q0.size(), 3);
    checkOutput("dir_u4_count", log_q1.size(), 3);
    checkOutput("dir_s5_count", log_q2.size(), 3);
    if (log_q0.size() == 3) begin
      checkOutput("s4_max_data", log_q0[0].d, 16'd12);
      checkOutput("s4_max_idx", log_q0[0].i, 2);
      checkOutput("s4_max_lat", log_q0[0].c, a + 1);
      checkOutput("s4_tie_data", log_q0[1].d, 16'd9);
      checkOutput("s4_tie_idx", log_q0[1].i, 0);
      checkOutput("s4_tie_cyc", log_q0[1].c, a + 2);
      checkOutput("s4_min_data", log_q0[2].d, 16'd1);
      checkOutput("s4_min_idx", log_q0[2].i, 1);
      checkOutput("s4_min_cyc", log_q0[2].c, a + 3);
    end
    if (log_q1.size() == 3) begin
      checkOutput("u4_max_data", log_q1[0].d, 16'hFFFD);
      checkOutput("u4_max_idx", log_q1[0].i, 1);
    end
    if (log_q2.size() == 3) begin
      checkOutput("s5_max_data", log_q2[0].d, 16'd100);
      checkOutput("s5_max_idx", log_q2[0].i, 4);
      checkOutput("s5_max_lat", log_q2[0].c, a + 2);
      checkOutput("s5_min_data", log_q2[2].d, 16'd1);
      checkOutput("s5_min_idx", log_q2[2].i, 4);
      checkOutput("s5_min_cyc", log_q2[2].c, a + 4);
    end

    // Eight-transaction stream with a three-cycle output stall in the middle.
    base0 = log_q0.size();
    n = 0; stall = 0;
    randomizeData();
    imin = 1'($urandom);
    for (int it = 0; it < 60 && n < 8; it++) begin
      ordy = 1'b1;
      if (n == 4 && stall < 3) begin
        ordy = 1'b0;
        stall++;
      end
      acc = ordy || !mv[0][1];
      applyStimulus(1'b1, imin, ordy, 1'b0);
      if (acc) begin
        n++;
        randomizeData();
        imin = 1'($urandom);
      end
    end
    checkOutput("bp_accepted", n, 8);
    for (int c = 0; c < 4; c++) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("bp_delivered", log_q0.size() - base0, 8);

    for (int c = 0; c < 60; c++) begin
      randomizeData();
      applyStimulus(1'($urandom), 1'($urandom), ($urandom_range(0, 3) != 0), 1'b0);
    end
    for (int c = 0; c < 4; c++) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);

    // Two transactions in flight, then a reset pulse before the 5-channel results emerge.
    base2 = log_q2.size();
    randomizeData();
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
    randomizeData();
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
    for (int c = 0; c < 3; c++) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("rst_no_stale", log_q2.size(), base2);

    r = cyc + 1;
    v4 = '{16'd3, 16'd3, 16'd2, 16'd2};
    v5 = '{8'd1, 8'hF0, 8'd5, 8'd5, 8'd2};
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
    for (int c = 0; c < 4; c++) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("post_rst_count", log_q2.size(), base2 + 1);
    if (log_q2.size() == base2 + 1) begin
      checkOutput("post_rst_data", log_q2[base2].d, 16'h00F0);
      checkOutput("post_rst_idx", log_q2[base2].i, 1);
      checkOutput("post_rst_lat", log_q2[base2].c, r + 2);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
